// File: rtl/frame_window.sv
`default_nettype none
// ============================================================================
//  Module   : frame_window
//  Purpose  : Circular frame buffer with Q1.15 windowing. Every frame trigger
//             streams FRAME_LEN windowed samples, oldest first, as a single
//             contiguous burst for the downstream Goertzel stage.
//  Options  : FRAME_PREEMPH_EN - when defined, a first-order pre-emphasis
//             filter (y = x - 0.97*x_prev) is applied before the RAM write.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_window #(
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [15:0]            sample_in,
    input  logic                          sample_valid,
    input  logic                          coef_wr_en,
    input  logic [$clog2(FRAME_LEN)-1:0]  coef_addr,
    input  logic signed [15:0]            coef_data,
    output logic signed [15:0]            framed_out,
    output logic                          framed_valid,
    output logic                          frame_start,
    output logic                          frame_last,
    output logic                          busy,
    output logic                          frame_overrun
);

    localparam int AW = $clog2(FRAME_LEN);

    localparam logic [0:0]        c_ST_FILL   = 1'b0;
    localparam logic [0:0]        c_ST_RUN    = 1'b1;
    localparam logic [AW-1:0]     c_FILL_LAST = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0]     c_HOP_LAST  = AW'(HOP - 1);
    localparam logic [AW-1:0]     c_IDX_LAST  = AW'(FRAME_LEN - 1);
    localparam logic signed [31:0] c_ROUND    = 32'sd16384;

    // Storage
    logic signed [15:0] r_sample_mem [FRAME_LEN];
    logic signed [15:0] r_coef_mem   [FRAME_LEN];

    // Write side / trigger generation
    logic [0:0]         r_state;
    logic [AW-1:0]      r_cnt;
    logic [AW-1:0]      r_wr_ptr;
    logic               w_trigger;
    logic signed [15:0] w_wr_data;

    // Readout side
    logic               r_busy;
    logic               r_overrun;
    logic [AW-1:0]      r_start;
    logic [AW-1:0]      r_rd_idx;
    logic [AW-1:0]      w_rd_addr;
    logic signed [15:0] r_rd_sample;
    logic signed [15:0] r_rd_coef;
    logic               r_rd_valid;
    logic               r_rd_first;
    logic               r_rd_last;

    // Window arithmetic / output stage
    logic signed [31:0] w_samp_ext;
    logic signed [31:0] w_coef_ext;
    logic signed [31:0] w_win_round;
    logic signed [15:0] w_win_sat;
    logic signed [15:0] r_out;
    logic               r_out_valid;
    logic               r_out_first;
    logic               r_out_last;

`ifdef FRAME_PREEMPH_EN
    logic signed [15:0] r_x_prev;
    logic signed [31:0] w_x_ext;
    logic signed [31:0] w_xp_ext;
    logic signed [31:0] w_pe_scaled;
    logic signed [31:0] w_pe_diff;

    assign w_x_ext     = {{16{sample_in[15]}}, sample_in};
    assign w_xp_ext    = {{16{r_x_prev[15]}}, r_x_prev};
    // 31785 is 0.97 in Q15; arithmetic shift floors toward minus infinity
    assign w_pe_scaled = (w_xp_ext * 32'sd31785) >>> 15;
    assign w_pe_diff   = w_x_ext - w_pe_scaled;

    // Saturate the pre-emphasised sample back to 16 bits
    always_comb begin
        w_wr_data = w_pe_diff[15:0];
        if (w_pe_diff > 32'sd32767) begin
            w_wr_data = 16'sh7FFF;
        end else if (w_pe_diff < -32'sd32768) begin
            w_wr_data = 16'sh8000;
        end
    end

    // Previous raw sample for the pre-emphasis filter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_prev <= '0;
        end else if (sample_valid) begin
            r_x_prev <= sample_in;
        end
    end
`else
    assign w_wr_data = sample_in;
`endif

    // The FRAME_LEN-th sample after reset opens the first frame, then every HOP-th
    assign w_trigger = sample_valid &&
                       ((r_state == c_ST_FILL) ? (r_cnt == c_FILL_LAST)
                                               : (r_cnt == c_HOP_LAST));

    // Fill/run state machine, sample counter and write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_FILL;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
        end else if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_trigger) begin
                r_state <= c_ST_RUN;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + AW'(1);
            end
        end
    end

    // Readout sequencer: one address per cycle; a trigger while busy is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_start   <= '0;
            r_rd_idx  <= '0;
        end else begin
            if (r_busy) begin
                r_rd_idx <= r_rd_idx + AW'(1);
                if (r_rd_idx == c_IDX_LAST) begin
                    r_busy <= 1'b0;
                end
            end
            if (w_trigger) begin
                if (r_busy) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_busy   <= 1'b1;
                    // Pointer after the trigger write is the oldest sample
                    r_start  <= r_wr_ptr + AW'(1);
                    r_rd_idx <= '0;
                end
            end
        end
    end

    assign w_rd_addr = r_start + r_rd_idx;

    // Sample and coefficient RAMs; reads return old data on a same-address write
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            r_sample_mem[r_wr_ptr] <= w_wr_data;
        end
        if (coef_wr_en && !r_busy) begin
            r_coef_mem[coef_addr] <= coef_data;
        end
        r_rd_sample <= r_sample_mem[w_rd_addr];
        r_rd_coef   <= r_coef_mem[r_rd_idx];
    end

    // Qualifiers travelling alongside the RAM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= r_busy;
            r_rd_first <= r_busy && (r_rd_idx == '0);
            r_rd_last  <= r_busy && (r_rd_idx == c_IDX_LAST);
        end
    end

    assign w_samp_ext  = {{16{r_rd_sample[15]}}, r_rd_sample};
    assign w_coef_ext  = {{16{r_rd_coef[15]}}, r_rd_coef};
    assign w_win_round = (w_samp_ext * w_coef_ext + c_ROUND) >>> 15;

    // Clamp the rounded product; only -1.0 * -1.0 can exceed the range
    always_comb begin
        w_win_sat = w_win_round[15:0];
        if (w_win_round > 32'sd32767) begin
            w_win_sat = 16'sh7FFF;
        end else if (w_win_round < -32'sd32768) begin
            w_win_sat = 16'sh8000;
        end
    end

    // Registered windowed output and framing flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= r_rd_valid;
            r_out_first <= r_rd_first;
            r_out_last  <= r_rd_last;
            if (r_rd_valid) begin
                r_out <= w_win_sat;
            end
        end
    end

    assign framed_out    = r_out;
    assign framed_valid  = r_out_valid;
    assign frame_start   = r_out_first;
    assign frame_last    = r_out_last;
    assign busy          = r_busy;
    assign frame_overrun = r_overrun;

endmodule
`default_nettype wire
